// File: rtl/video_timing_bg.sv
// video_timing_bg
//   Head of the video pipeline. Generates raster timing (hcount/vcount,
//   hsync/vsync, hblnk/vblnk) and a background fill: sky above the horizon,
//   ground from the horizon line down. Every bus field is registered in the
//   same pclk cycle, so count and decode are always mutually consistent.
//
//   Optional feature macro: VIDEO_TEST_PATTERN_EN
//     defined   -> active area shows 8 vertical colour bars instead of the
//                  sky/ground fill (blanking still forces black)
//     undefined -> sky/ground fill only
//
// Ports
//   pclk          in   pixel clock
//   rst           in   asynchronous, active-high reset
//   enable        in   1 = counters advance, 0 = every output register holds
//   video_bus_out out  {hcount[10:0], vcount[10:0], hsync, vsync,
//                       hblnk, vblnk, rgb[11:0]}, `BUS_WIDTH+1 bits
//   frame_start   out  high while the bus shows hcount=0, vcount=0
//   frame_count   out  frames completed, wraps 255 -> 0

`ifndef BUS_WIDTH
`define BUS_WIDTH 37
`endif

module video_timing_bg #(
    parameter int          H_VISIBLE  = 800,
    parameter int          H_FP       = 40,
    parameter int          H_SYNC     = 128,
    parameter int          H_BP       = 88,
    parameter int          V_VISIBLE  = 600,
    parameter int          V_FP       = 1,
    parameter int          V_SYNC     = 4,
    parameter int          V_BP       = 23,
    parameter int          SYNC_POL   = 1,
    parameter int          HORIZON    = 450,
    parameter logic [11:0] SKY_RGB    = 12'h8_C_F,
    parameter logic [11:0] GROUND_RGB = 12'h2_6_1
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               enable,
    output logic [`BUS_WIDTH:0] video_bus_out,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    // 11-bit counters cannot represent a longer raster.
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_width_check
        $error("video_timing_bg: H_TOTAL and V_TOTAL must be <= 2048");
    end

    // Comparisons are done in 32 bits so a window ending exactly at 2048
    // is not truncated.
    function automatic int widen(input logic [10:0] c);
        return int'({21'd0, c});
    endfunction

    function automatic logic sync_level(input logic [10:0] c, input int lo, input int hi);
        if (widen(c) >= lo && widen(c) < hi)
            return SYNC_ACT;
        return ~SYNC_ACT;
    endfunction

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    if (BAR_W < 1) begin : g_bar_check
        $error("video_timing_bg: H_VISIBLE must be >= 8 for the test pattern");
    end

    function automatic logic [11:0] fill_colour(input logic [10:0] h, input logic blank);
        int idx;
        idx = widen(h) / BAR_W;
        if (blank)
            return 12'h000;
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction
`else
    function automatic logic [11:0] fill_colour(input logic [10:0] v, input logic blank);
        if (blank)
            return 12'h000;
        if (widen(v) < HORIZON)
            return SKY_RGB;
        return GROUND_RGB;
    endfunction
`endif

    logic [10:0] hcount_p0, hcount_p1;
    logic [10:0] vcount_p0, vcount_p1;
    logic [7:0]  frame_count_p0, frame_count_p1;
    logic        hsync_p0, hsync_p1;
    logic        vsync_p0, vsync_p1;
    logic        hblnk_p0, hblnk_p1;
    logic        vblnk_p0, vblnk_p1;
    logic [11:0] rgb_p0, rgb_p1;
    logic        frame_start_p0, frame_start_p1;

    // ---- p0: next counter value and its decode ----
    // Decode works on the next count so it lands in the same register
    // update as the count itself: zero skew on the bus.
    always_comb begin
        hcount_p0      = hcount_p1 + 11'd1;
        vcount_p0      = vcount_p1;
        frame_count_p0 = frame_count_p1;
        if (hcount_p1 == H_LAST) begin
            hcount_p0 = '0;
            if (vcount_p1 == V_LAST) begin
                vcount_p0      = '0;
                frame_count_p0 = frame_count_p1 + 8'd1;
            end else begin
                vcount_p0 = vcount_p1 + 11'd1;
            end
        end

        hblnk_p0       = (widen(hcount_p0) >= H_VISIBLE);
        vblnk_p0       = (widen(vcount_p0) >= V_VISIBLE);
        hsync_p0       = sync_level(hcount_p0, H_SYNC_START, H_SYNC_END);
        vsync_p0       = sync_level(vcount_p0, V_SYNC_START, V_SYNC_END);
`ifdef VIDEO_TEST_PATTERN_EN
        rgb_p0         = fill_colour(hcount_p0, hblnk_p0 | vblnk_p0);
`else
        rgb_p0         = fill_colour(vcount_p0, hblnk_p0 | vblnk_p0);
`endif
        frame_start_p0 = (hcount_p0 == 11'd0) && (vcount_p0 == 11'd0);
    end

    // ---- p1: output register, the bus itself ----
    // With enable low everything holds, including a pending frame_start.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_p1      <= '0;
            vcount_p1      <= '0;
            frame_count_p1 <= '0;
            hsync_p1       <= ~SYNC_ACT;
            vsync_p1       <= ~SYNC_ACT;
            hblnk_p1       <= 1'b0;
            vblnk_p1       <= 1'b0;
            rgb_p1         <= 12'h000;
            frame_start_p1 <= 1'b0;
        end else if (enable) begin
            hcount_p1      <= hcount_p0;
            vcount_p1      <= vcount_p0;
            frame_count_p1 <= frame_count_p0;
            hsync_p1       <= hsync_p0;
            vsync_p1       <= vsync_p0;
            hblnk_p1       <= hblnk_p0;
            vblnk_p1       <= vblnk_p0;
            rgb_p1         <= rgb_p0;
            frame_start_p1 <= frame_start_p0;
        end
    end

    assign video_bus_out = {hcount_p1, vcount_p1, hsync_p1, vsync_p1,
                            hblnk_p1, vblnk_p1, rgb_p1};
    assign frame_start   = frame_start_p1;
    assign frame_count   = frame_count_p1;

endmodule

// File: tb/tb_video_timing_bg.sv
// Testbench for video_timing_bg on a reduced raster (12 x 9, 108 pixels per
// frame) so that full frames and the 256-frame wrap stay short.

module tb_video_timing_bg;

    localparam int HV = 8, HFP = 1, HSW = 2, HBP = 1;
    localparam int VV = 6, VFP = 1, VSW = 1, VBP = 1;
    localparam int HOR = 4;
    localparam int HT = HV + HFP + HSW + HBP;   // 12
    localparam int VT = VV + VFP + VSW + VBP;   // 9
    localparam int FRAME = HT * VT;             // 108
    localparam logic        POL_B = 1'b1;
    localparam logic [11:0] SKY   = 12'h8CF;
    localparam logic [11:0] GND   = 12'h261;
    localparam logic [37:0] RST_BUS = {11'd0, 11'd0, !POL_B, !POL_B, 2'b00, 12'h000};

    logic        pclk;
    logic        rst;
    logic        enable;
    logic [37:0] video_bus_out;
    logic        frame_start;
    logic [7:0]  frame_count;

    video_timing_bg #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1), .HORIZON(HOR), .SKY_RGB(SKY), .GROUND_RGB(GND)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .enable(enable),
        .video_bus_out(video_bus_out),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [37:0] bus;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;
    int m_h, m_v, m_fc;
    logic m_rst;
    int ecyc = 0;
    int last_fs = -1;
    int pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        logic hb, vb, hs, vs;
        logic [11:0] c;
        int idx;
        if (m_rst) begin
            e.bus = RST_BUS;
            e.fs  = 1'b0;
            e.fc  = 8'd0;
            return e;
        end
        hb = (m_h >= HV);
        vb = (m_v >= VV);
        hs = (m_h >= HV + HFP && m_h < HV + HFP + HSW) ? POL_B : !POL_B;
        vs = (m_v >= VV + VFP && m_v < VV + VFP + VSW) ? POL_B : !POL_B;
        idx = m_h / (HV / 8);
`ifdef VIDEO_TEST_PATTERN_EN
        c = (hb || vb) ? 12'h000 :
            {idx[2] ? 4'hF : 4'h0, idx[1] ? 4'hF : 4'h0, idx[0] ? 4'hF : 4'h0};
`else
        c = (hb || vb) ? 12'h000 : ((m_v < HOR) ? SKY : GND);
`endif
        e.bus = {11'(m_h), 11'(m_v), hs, vs, hb, vb, c};
        e.fs  = (m_h == 0 && m_v == 0);
        e.fc  = 8'(m_fc);
        return e;
    endfunction

    // One pclk: drive enable, push the model's prediction, compare after the edge.
    task automatic step(input logic en);
        exp_t e;
        enable = en;
        if (en) begin
            m_rst = 1'b0;
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v  = 0;
                    m_fc = (m_fc + 1) % 256;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        sb.push_back(model_exp());
        @(posedge pclk);
        #1;
        e = sb.pop_front();
        check("bus", video_bus_out, e.bus);
        check("frame_start", frame_start, e.fs);
        check("frame_count", frame_count, e.fc);
        if (en) begin
            ecyc++;
            if (frame_start) begin
                pulses++;
                if (last_fs >= 0)
                    check("fs_period", ecyc - last_fs, FRAME);
                last_fs = ecyc;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v && !m_rst) && n < 2 * FRAME) begin
            step(1'b1);
            n++;
        end
        if (!(m_h == h && m_v == v)) begin
            checks++;
            errors++;
            $display("FAIL reach actual=%0d/%0d required=%0d/%0d", m_h, m_v, h, v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef VIDEO_TEST_PATTERN_EN
        tbl.push_back('{0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
        tbl.push_back('{1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F});
        tbl.push_back('{4, 2, 1'b0, 1'b0, 1'b0, 1'b0, 12'hF00});
        tbl.push_back('{7, 2, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF});
        tbl.push_back('{8, 2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
        tbl.push_back('{3, 6, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000});
`else
        tbl.push_back('{1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h8CF});
        tbl.push_back('{1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 12'h261});
        tbl.push_back('{7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h261});
        tbl.push_back('{0, 6, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000});
        tbl.push_back('{3, 7, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000});
        tbl.push_back('{11, 7, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000});
        tbl.push_back('{0, 8, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000});
`endif
        tbl.push_back('{7, 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
        tbl.push_back('{8, 1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
        tbl.push_back('{9, 1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000});
        tbl.push_back('{10, 1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000});
        tbl.push_back('{11, 1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
`ifndef VIDEO_TEST_PATTERN_EN
        tbl[7].rgb = SKY;
`else
        tbl[6].rgb = 12'hFFF;
`endif

        // Reset state
        rst = 1'b1; enable = 1'b0;
        m_rst = 1'b1; m_h = 0; m_v = 0; m_fc = 0;
        repeat (2) @(posedge pclk);
        #1;
        check("reset_bus", video_bus_out, RST_BUS);
        check("reset_fs", frame_start, 1'b0);
        check("reset_fc", frame_count, 8'd0);
        rst = 1'b0;
        repeat (3) step(1'b0);

        // Decode / colour table
        for (int i = 0; i < tbl.size(); i++) begin
            run_to(tbl[i].h, tbl[i].v);
            check("tbl_h", video_bus_out[37:27], 11'(tbl[i].h));
            check("tbl_v", video_bus_out[26:16], 11'(tbl[i].v));
            check("tbl_hsync", video_bus_out[15], tbl[i].hs);
            check("tbl_vsync", video_bus_out[14], tbl[i].vs);
            check("tbl_hblnk", video_bus_out[13], tbl[i].hb);
            check("tbl_vblnk", video_bus_out[12], tbl[i].vb);
            check("tbl_rgb", video_bus_out[11:0], tbl[i].rgb);
        end

        // Several full frames
        repeat (3 * FRAME) step(1'b1);

        // Freeze mid-line and resume
        run_to(5, 1);
        repeat (50) step(1'b0);
        check("frozen_h", video_bus_out[37:27], 11'd5);
        step(1'b1);
        check("resume_h", video_bus_out[37:27], 11'd6);

        // frame_start held while disabled at 0/0
        run_to(0, 0);
        check("fs_at_origin", frame_start, 1'b1);
        repeat (10) step(1'b0);
        check("fs_held", frame_start, 1'b1);
        step(1'b1);
        check("fs_released", frame_start, 1'b0);

        // Asynchronous reset mid-line, no clock edge in between
        run_to(5, 2);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_bus", video_bus_out, RST_BUS);
        check("async_rst_fs", frame_start, 1'b0);
        check("async_rst_fc", frame_count, 8'd0);
        m_rst = 1'b1; m_h = 0; m_v = 0; m_fc = 0; last_fs = -1;
        @(posedge pclk);
        #1;
        check("rst_held_bus", video_bus_out, RST_BUS);
        rst = 1'b0;
        step(1'b1);
        check("restart_h", video_bus_out[37:27], 11'd1);

        // 256 frames: frame_count wraps to 0
        pulses = 0;
        repeat (256 * FRAME - 1) step(1'b1);
        check("wrap_pulses", pulses, 256);
        check("wrap_fc", frame_count, 8'd0);
        check("wrap_fs", frame_start, 1'b1);
        check("wrap_pos", video_bus_out[37:16], 22'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_bg.md
Name: video_timing_bg

Overview:
- Head of the video pipeline: generates raster timing (hcount/vcount, sync, blanking) and a background fill (sky above horizon, ground below).
- Drives the first video bus consumed by the sprite/image drawing stages downstream.
- Every field on its output bus is registered and mutually consistent in the same pclk cycle.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)
- HORIZON, 450, first vcount drawn in ground colour
- SKY_RGB, 12'h8_C_F, sky colour
- GROUND_RGB, 12'h2_6_1, ground colour

Ports:
- pclk  input  1  pixel clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  1 = counters advance; 0 = freeze all outputs
- video_bus_out  output  `BUS_WIDTH+1  packed video bus (hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]) via the standard bus macros
- frame_start  output  1  one-cycle pulse at hcount=0, vcount=0
- frame_count  output  8  frames completed, wraps 255->0

Behaviour:
- Clock: one clock (pclk). Reset: asynchronous, active-high (rst). All state resets immediately on rst; no clock is needed.
- Reset values:
  - hcount=0, vcount=0, hblnk=0, vblnk=0
  - hsync=vsync=~SYNC_POL (inactive)
  - rgb=12'h000, frame_start=0, frame_count=0
- Totals: H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (1056); V_TOTAL (628).
- Counting, when enable=1, on each pclk:
  - hcount increments.
  - At hcount=H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 together with the hcount wrap, vcount wraps to 0 and frame_count increments (mod 256).
- enable=0: all registers hold, including rgb, sync and frame_start. A held frame_start=1 stays high until enable returns and the counter moves.
- Decode is computed from the next counter value and registered alongside it, so there is zero skew between count and decode on the bus:
  - hblnk=1 iff hcount>=H_VISIBLE
  - hsync active iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC
  - Vertical signals use the same rules on vcount.
- rgb:
  - 12'h000 whenever hblnk|vblnk.
  - Otherwise SKY_RGB if vcount<HORIZON, else GROUND_RGB.
- frame_start=1 for exactly the cycle where the bus shows hcount=0, vcount=0.
  - It is not asserted on the first cycle out of reset; the first pulse comes after a full frame.
- Width rule: counters are 11 bits. Parameters must give H_TOTAL, V_TOTAL <= 2048; elaboration fails otherwise.
- Latency: the counter-to-bus relationship is combinational-free. Downstream stages see the bus one register after the counter update.
- Reset mid-frame: return to reset values immediately; counting restarts at 0/0 on the first enabled edge after rst deasserts.

Optional Feature:
- Macro: VIDEO_TEST_PATTERN_EN.
- Defined: in the active area, rgb shows 8 vertical colour bars, each H_VISIBLE/8 wide. Bar index = hcount/(H_VISIBLE/8), and bar colour = {index[2]?4'hF:4'h0, index[1]?4'hF:4'h0, index[0]?4'hF:4'h0}. The horizon/sky/ground logic is bypassed; blanking still forces 12'h000.
- Undefined: background fill only; no bar logic is synthesised.

Test Plan:
- Assert rst mid-line at hcount=300 with no clock edge -> outputs immediately read 0/0, syncs inactive, rgb=000; frame_count=0.
- Run 1 line with enable=1 -> hblnk rises at hcount=800; hsync active for hcount 840..967 (128 cycles); hcount wraps 1055->0 and vcount 0->1 on the same edge.
- Run a full frame -> vsync active on lines 601..604; vblnk for vcount>=600; frame_start pulses once per 1056*628=663168 cycles; frame_count increments.
- Check colour: (hcount=10, vcount=449) -> SKY_RGB 8CF; (10, 450) -> GROUND_RGB 261; (810, 100) -> 000.
- Drop enable for 50 cycles at hcount=500 -> bus frozen bit-for-bit; resumes at hcount=501.
- With VIDEO_TEST_PATTERN_EN: hcount=0 -> 000; hcount=100 -> 00F; hcount=799 -> FFF; hcount=800 -> 000 (blank). Run 256 frames -> frame_count wraps to 0.
